// File: rtl/pc_sequencer.sv
// Fetch controller for the RV32IM core: drives the PC register, the instruction-memory
// request/grant/response handshake and the valid/ready instruction interface to decode.
module pc_sequencer #(
    parameter int AddrSize = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AddrSize-1:0] pc_curr,
    output logic [AddrSize-1:0] pc_next,
    input  logic                halt,
    output logic                imem_req,
    output logic [AddrSize-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    output logic [AddrSize-1:0] if_pc,
    output logic [31:0]         if_instr,
    input  logic                if_ready,
    input  logic                redirect_valid,
    input  logic [AddrSize-1:0] redirect_target
);

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_e;

    state_e              state;
    state_e              state_nxt;
    logic                kill;
    logic                kill_nxt;
    logic                capture;
    logic                transfer;
    logic [AddrSize-1:0] target_aligned;
    logic                unused_target_bits;

    assign transfer           = (state == HOLD) && if_ready;
    assign target_aligned     = {redirect_target[AddrSize-1:2], 2'b00};
    assign unused_target_bits = ^redirect_target[1:0];

    assign imem_req  = (state == REQ);
    assign if_valid  = (state == HOLD);
    assign imem_addr = pc_curr;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the values from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        capture   = 1'b0;

        if (redirect_valid) begin
            pc_next = target_aligned;
        end else if (transfer) begin
            pc_next = pc_curr + AddrSize'(4);
        end else begin
            pc_next = pc_curr;
        end

        case (state)
            IDLE: begin
                if (!halt) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // A redirect racing the grant turns the accepted fetch into a wrong-path one.
                if (imem_gnt) begin
                    state_nxt = WAIT;
                    kill_nxt  = redirect_valid;
                end else if (halt) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill || redirect_valid) begin
                        kill_nxt  = 1'b0;
                        state_nxt = halt ? IDLE : REQ;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || if_ready) begin
                    state_nxt = halt ? IDLE : REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
                kill_nxt  = 1'b0;
            end
        endcase
    end

    // NOTE: the presented-instruction registers are reset so decode sees a NOP at a
    // known PC even before the first fetch completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_pc    <= '0;
            if_instr <= NopInstr;
        end else if (capture) begin
            if_pc    <= pc_curr;
            if_instr <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: PC register and instruction memory models,
// a fetch scoreboard, a redirect vector table and hand-written corner-case sequences.
module tb_pc_sequencer;

    localparam int          AW = 32;
    localparam logic [31:0] K  = 32'hA5A5_A5A5;

    typedef enum int {PH_REQ, PH_GNT, PH_WAIT, PH_RVALID, PH_HOLD} phase_e;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    typedef struct {
        phase_e      phase;
        int          latency;
        logic [31:0] target;
        logic [31:0] exp_pc;
        string       name;
    } redir_vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_curr;
    logic [AW-1:0] pc_next;
    logic          halt;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [31:0]   if_instr;
    logic          if_ready;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // memory model state
    int          latency   = 1;
    bit          gnt_en    = 1'b1;
    bit          pending   = 1'b0;
    int          cnt       = 0;
    logic [31:0] paddr     = '0;
    bit          gnt_last  = 1'b0;
    logic [31:0] addr_last = '0;

    // scoreboard / monitor state
    fetch_t sb_q[$];
    bit     sb_on      = 1'b0;
    bit     prev_valid = 1'b0;
    int     rise_q[$];

    redir_vec_t vecs[5];

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_curr <= '0;
        else       pc_curr <= pc_next;
    end

    pc_sequencer #(.AddrSize(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_curr         (pc_curr),
        .pc_next         (pc_next),
        .halt            (halt),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_ready        (if_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responses: grant while idle, rvalid `latency` cycles after the grant.
    task automatic mem_update();
        if (gnt_last) begin
            pending = 1'b1;
            cnt     = latency;
            paddr   = addr_last;
        end
        gnt_last    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pending) begin
            cnt--;
            if (cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = paddr ^ K;
                pending     = 1'b0;
            end
        end
        imem_gnt = gnt_en && imem_req && !pending;
    endtask

    task automatic tick();
        fetch_t e;
        #2;
        if (if_valid && !prev_valid) rise_q.push_back(cyc);
        prev_valid = if_valid;
        if (sb_on && if_valid && if_ready) begin
            if (sb_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_xfer: got if_pc=%h if_instr=%h, expected no transfer", if_pc, if_instr);
            end else begin
                e = sb_q.pop_front();
                check("xfer_pc", if_pc, e.pc);
                check("xfer_instr", if_instr, e.instr);
            end
        end
        gnt_last  = imem_req && imem_gnt;
        addr_last = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
        mem_update();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        halt           = 1'b0;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = '0;
        gnt_en         = 1'b1;
        latency        = 1;
        pending        = 1'b0;
        gnt_last       = 1'b0;
        sb_on          = 1'b0;
        sb_q.delete();
        rise_q.delete();
        @(posedge clk);
        #1;
        mem_update();
        check("rst_if_valid", if_valid, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 32'h0000_0013);
        check("rst_pc_next", pc_next, 0);
        reset      = 1'b0;
        cyc        = 0;
        prev_valid = 1'b0;
    endtask

    function automatic bit phase_hit(input phase_e p);
        case (p)
            PH_REQ:    phase_hit = imem_req && !imem_gnt;
            PH_GNT:    phase_hit = imem_req && imem_gnt;
            PH_WAIT:   phase_hit = pending && !imem_rvalid && !imem_req;
            PH_RVALID: phase_hit = imem_rvalid;
            default:   phase_hit = if_valid;
        endcase
    endfunction

    task automatic wait_phase(input phase_e p, input int budget, input string name);
        int n = 0;
        while (!phase_hit(p) && n < budget) begin
            tick();
            n++;
        end
        check(name, phase_hit(p), 1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    task automatic run_redirect(input redir_vec_t v);
        int n = 0;
        do_reset();
        latency = v.latency;
        if (v.phase == PH_REQ) gnt_en = 1'b0;
        wait_phase(v.phase, 20, {v.name, "_reach"});
        redirect_valid  = 1'b1;
        redirect_target = v.target;
        #1;
        check({v.name, "_pc_next"}, pc_next, v.exp_pc);
        tick();
        redirect_valid = 1'b0;
        gnt_en         = 1'b1;
        check({v.name, "_pc_curr"}, pc_curr, v.exp_pc);
        check({v.name, "_valid_drop"}, if_valid, 0);
        sb_q.delete();
        sb_q.push_back('{v.exp_pc, v.exp_pc ^ K});
        sb_on = 1'b1;
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        check({v.name, "_req_seen"}, imem_req, 1);
        check({v.name, "_req_addr"}, imem_addr, v.exp_pc);
        wait_drain(20, {v.name, "_drained"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_pc;
        logic [31:0] snap_instr;
        logic [31:0] snap_pcc;

        vecs[0] = '{PH_REQ,    1, 32'h0000_0502, 32'h0000_0500, "redir_req"};
        vecs[1] = '{PH_GNT,    1, 32'h0000_0200, 32'h0000_0200, "redir_gnt"};
        vecs[2] = '{PH_WAIT,   3, 32'h0000_0103, 32'h0000_0100, "redir_wait"};
        vecs[3] = '{PH_RVALID, 2, 32'h0000_0301, 32'h0000_0300, "redir_rvalid"};
        vecs[4] = '{PH_HOLD,   1, 32'h0000_0404, 32'h0000_0404, "redir_hold_xfer"};

        reset = 1'b1; halt = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        // Sequential zero-wait fetch: PCs 0,4,8,12 with if_valid rising at 3,6,9,12.
        do_reset();
        for (int a = 0; a < 16; a += 4) sb_q.push_back('{32'(a), 32'(a) ^ K});
        sb_on = 1'b1;
        check("c0_pc_next", pc_next, 0);
        check("c0_idle", imem_req, 0);
        tick();
        check("c1_req", imem_req, 1);
        check("c1_addr", imem_addr, 0);
        for (int i = 0; i < 12; i++) tick();
        check("seq_drained", sb_q.size(), 0);
        check("seq_rise_count", rise_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("seq_rise_cycle", (i < rise_q.size()) ? rise_q[i] : -1, 3 * (i + 1));
        end

        // Back-pressure: decode stalls for 5 cycles in HOLD.
        if_ready = 1'b0;
        sb_q.push_back('{32'h10, 32'h10 ^ K});
        wait_phase(PH_HOLD, 10, "stall_reach");
        snap_pc    = if_pc;
        snap_instr = if_instr;
        snap_pcc   = pc_curr;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", if_valid, 1);
            check("stall_if_pc", if_pc, snap_pc);
            check("stall_if_instr", if_instr, snap_instr);
            check("stall_pc_curr", pc_curr, snap_pcc);
            tick();
        end
        if_ready = 1'b1;
        wait_drain(5, "stall_drained");

        // Redirect vectors.
        for (int i = 0; i < 5; i++) run_redirect(vecs[i]);

        // Halt in IDLE and in REQ without grant.
        do_reset();
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_no_req", imem_req, 0);
        end
        halt   = 1'b0;
        gnt_en = 1'b0;
        tick();
        check("halt_release_req", imem_req, 1);
        halt = 1'b1;
        tick();
        check("halt_req_to_idle", imem_req, 0);
        halt   = 1'b0;
        gnt_en = 1'b1;

        // PC wraparound: redirect from IDLE to the top word, then transfer.
        do_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        #1;
        check("wrap_target_mask", pc_next, 32'hFFFF_FFFC);
        sb_q.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC ^ K});
        sb_on = 1'b1;
        tick();
        redirect_valid = 1'b0;
        wait_phase(PH_HOLD, 10, "wrap_reach");
        check("wrap_pc_next", pc_next, 0);
        sb_q.push_back('{32'h0, 32'h0 ^ K});
        tick();
        check("wrap_pc_curr", pc_curr, 0);
        wait_drain(10, "wrap_drained");

        // Reset during WAIT; the stale response arrives after release and is ignored.
        do_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        sb_q.push_back('{32'h40, 32'h40 ^ K});
        sb_on = 1'b1;
        tick();
        redirect_valid = 1'b0;
        wait_drain(10, "stale_pre_drained");
        latency = 4;
        wait_phase(PH_WAIT, 10, "stale_reach_wait");
        reset = 1'b1;
        #1;
        check("async_rst_if_pc", if_pc, 0);
        check("async_rst_if_instr", if_instr, 32'h0000_0013);
        check("async_rst_req", imem_req, 0);
        @(posedge clk);
        #1;
        mem_update();
        reset = 1'b0;
        cyc   = 0;
        sb_q.push_back('{32'h0, 32'h0 ^ K});
        wait_drain(25, "stale_drained");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch controller for the RV32IM core: it sequences the program counter register and the instruction-memory request/grant/response handshake. It produces `pc_next` for the PC register, whose output returns as `pc_curr`. It presents fetched instructions to decode with a valid/ready handshake. It applies control-flow redirects from execute, including killing an in-flight fetch.

## Interface
- `AddrSize`, default 32: PC and instruction address width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `pc_curr`  in  AddrSize  current PC from the PC register, which resets to 0.
- `pc_next`  out  AddrSize  next PC to the PC register, which loads it every cycle.
- `halt`  in  1  when high, no new fetch request is started.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  AddrSize  fetch address; always equals `pc_curr`.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid.
- `imem_rdata`  in  32  response instruction word.
- `if_valid`  out  1  instruction valid to decode.
- `if_pc`  out  AddrSize  PC of the presented instruction.
- `if_instr`  out  32  presented instruction.
- `if_ready`  in  1  decode accepts; a transfer occurs when `if_valid && if_ready`.
- `redirect_valid`  in  1  one-cycle redirect pulse from execute (branch/jal/jalr/trap).
- `redirect_target`  in  AddrSize  redirect address; bits [1:0] are ignored and treated as 0.

## Operation
- States: IDLE, REQ, WAIT, HOLD. A separate `kill` flag marks an in-flight fetch as wrong-path.
- IDLE: `imem_req`=0. Moves to REQ when `halt`=0.
- REQ: `imem_req`=1.
  - On `imem_gnt`, go to WAIT.
  - On `halt` with no grant, go to IDLE.
- WAIT: waits for `imem_rvalid`.
  - If `kill`=0: capture `imem_rdata` into `if_instr` and `pc_curr` into `if_pc`, then go to HOLD.
  - If `kill`=1: discard the data, clear `kill`, then go to REQ (or IDLE if `halt`).
- HOLD: `if_valid`=1. On transfer, go to REQ (or IDLE if `halt`).
- `pc_next` (combinational), in priority order:
  - `{redirect_target[AddrSize-1:2],2'b00}` when `redirect_valid`;
  - else `pc_curr + 4` (mod 2^AddrSize) on a HOLD transfer;
  - else `pc_curr`.
- Redirect effect by state:
  - IDLE or REQ without grant: PC updates; the request continues at the new address.
  - REQ with `imem_gnt` in the same cycle: go to WAIT with `kill`=1.
  - WAIT: set `kill`=1. If `imem_rvalid` arrives in the same cycle, discard that data and go to REQ.
  - HOLD: `if_valid` drops next cycle and the state goes to REQ. A simultaneous transfer still counts as consumed by decode.
- `imem_rvalid` outside WAIT is ignored. This covers stale responses after reset.
- Reset values:
  - state IDLE, `kill`=0;
  - `if_valid`=0, `imem_req`=0;
  - `if_pc`=0, `if_instr`=0x00000013 (NOP);
  - `pc_next`=`pc_curr`, which is 0.

## Timing
- Reset is asynchronous. Reset mid-fetch returns to IDLE immediately, and the outstanding response is dropped.
- First `imem_req` is seen on the first cycle after reset deassertion: cycle 0 is IDLE, cycle 1 is REQ.
- Zero-wait memory (gnt in the REQ cycle, rvalid the next cycle):
  - `if_valid` rises 2 cycles after the granted REQ cycle;
  - steady throughput is one instruction per 3 cycles with `if_ready`=1.
- A redirect in cycle t is visible on `pc_curr` at t+1. The first fetch at the target is issued no later than the cycle after the killed response returns.
- `imem_addr` is stable from REQ entry until grant, except in the cycle after a redirect.

## Test plan
- Reset, `halt`=0, zero-wait memory returning `rdata`=addr^0xA5A5A5A5:
  - `if_pc` sequence is 0, 4, 8, 12;
  - `if_valid` rises at cycles 3, 6, 9, 12.
- `if_ready`=0 for 5 cycles in HOLD: `if_valid`, `if_pc`, `if_instr` and `pc_curr` are all stable.
- Redirect to 0x103 while in WAIT with a 3-cycle response latency:
  - the response is discarded;
  - next `imem_addr`=0x100;
  - next `if_pc`=0x100.
- Redirect in the same cycle as `imem_gnt`, and redirect in the same cycle as `imem_rvalid`: neither old instruction ever appears on `if_valid`.
- Redirect and transfer in the same HOLD cycle: `pc_next`=target, not `pc_curr+4`.
- `pc_curr`=0xFFFFFFFC transfer → `pc_next`=0. Assert `reset` while in WAIT, then send `imem_rvalid` after release → the response is ignored and fetch restarts at 0.
